// File: rtl/aggregation_flag_reader_pkg.sv
// Shared word width and node memory map for the forAggregation flag handshake,
// plus the clamp and saturation helpers used by the flag reader.
package aggregation_flag_reader_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ACC_WIDTH  = WORD_WIDTH + 4;

    localparam logic [WORD_WIDTH-1:0] FLAG_ADDR  = 16'h0002;
    localparam logic [WORD_WIDTH-1:0] COUNT_ADDR = 16'h0003;
    localparam logic [WORD_WIDTH-1:0] AGG_ADDR   = 16'h0004;
    localparam logic [WORD_WIDTH-1:0] PKT_BASE   = 16'h0010;

    function automatic logic [WORD_WIDTH-1:0] clamp_count(
        input logic [WORD_WIDTH-1:0] raw,
        input logic [WORD_WIDTH-1:0] limit
    );
        logic [WORD_WIDTH-1:0] res;
        if (raw > limit) begin
            res = limit;
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Any bit above the word range means the true sum no longer fits.
    function automatic logic [WORD_WIDTH-1:0] sat_word(input logic [ACC_WIDTH-1:0] acc);
        logic [WORD_WIDTH-1:0] res;
        if (acc[ACC_WIDTH-1:WORD_WIDTH] != {(ACC_WIDTH-WORD_WIDTH){1'b0}}) begin
            res = {WORD_WIDTH{1'b1}};
        end else begin
            res = acc[WORD_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/aggregation_flag_reader_if.sv
// Shared data memory port as seen by the flag reader (master) and the memory (slave).
interface aggregation_flag_reader_if;
    import aggregation_flag_reader_pkg::*;

    logic [WORD_WIDTH-1:0] address;
    logic                  wr_en;
    logic [WORD_WIDTH-1:0] data_out;
    logic [WORD_WIDTH-1:0] data_in;

    modport master (output address, output wr_en, output data_out, input data_in);
    modport slave  (input address, input wr_en, input data_out, output data_in);

endinterface

// File: rtl/aggregation_flag_reader_mem_read_waiter.sv
// Counts the memory read latency after each new read address and flags the
// single cycle in which data_in holds the word for that address.
module aggregation_flag_reader_mem_read_waiter #(
    parameter int READ_LAT = 1
) (
    input  logic clock,
    input  logic nrst,
    input  logic load,
    output logic rd_valid
);

    logic [1:0] wait_cnt_r;

    // Reload on every new address, then count down to the valid cycle.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            wait_cnt_r <= 2'd0;
        end else if (load) begin
            wait_cnt_r <= 2'(READ_LAT);
        end else if (wait_cnt_r != 2'd0) begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign rd_valid = (wait_cnt_r == 2'd1);

endmodule

// File: rtl/aggregation_flag_reader.sv
// Consumer side of the forAggregation flag: reads the flag, sums the pending
// packet payloads, writes the aggregate back and clears the flag.
module aggregation_flag_reader
    import aggregation_flag_reader_pkg::*;
#(
    parameter int MAX_PKTS = 8,
    parameter int READ_LAT = 1
) (
    input  logic                          clock,
    input  logic                          nrst,
    input  logic                          en,
    input  logic                          start,
    aggregation_flag_reader_if.master     bus,
    output logic                          aggregated,
    output logic [WORD_WIDTH-1:0]         agg_value,
    output logic [WORD_WIDTH-1:0]         pkt_count,
    output logic                          done
);

    typedef enum logic [2:0] {
        ARM, IDLE, RD_FLAG, RD_CNT, RD_PKT, WR_AGG, CLR_FLAG, FINISH
    } state_t;

    localparam logic [WORD_WIDTH-1:0] MAX_PKTS_W = WORD_WIDTH'(MAX_PKTS);
    localparam logic [WORD_WIDTH-1:0] ONE_W      = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WORD_WIDTH-1:0] ZERO_W     = {WORD_WIDTH{1'b0}};

    state_t                state_r, state_s;
    logic [WORD_WIDTH-1:0] address_r, address_s;
    logic [WORD_WIDTH-1:0] data_out_r, data_out_s;
    logic                  wr_en_r, wr_en_s;
    logic                  aggregated_r, aggregated_s;
    logic [WORD_WIDTH-1:0] agg_value_r, agg_value_s;
    logic [WORD_WIDTH-1:0] pkt_count_r, pkt_count_s;
    logic                  done_r, done_s;
    logic [ACC_WIDTH-1:0]  acc_r, acc_s;
    logic [WORD_WIDTH-1:0] idx_r, idx_s;
    logic                  addr_pend_r, addr_pend_s;
    logic                  load_s;
    logic                  rd_valid_s;
    logic [WORD_WIDTH-1:0] clamped_s;

    aggregation_flag_reader_mem_read_waiter #(.READ_LAT(READ_LAT)) u_waiter (
        .clock    (clock),
        .nrst     (nrst),
        .load     (load_s),
        .rd_valid (rd_valid_s)
    );

    assign clamped_s = clamp_count(bus.data_in, MAX_PKTS_W);

    // Next-state and next-output logic; packet addresses go out one cycle after the index update.
    always_comb begin
        state_s      = state_r;
        address_s    = address_r;
        data_out_s   = data_out_r;
        wr_en_s      = 1'b0;
        aggregated_s = aggregated_r;
        agg_value_s  = agg_value_r;
        pkt_count_s  = pkt_count_r;
        done_s       = done_r;
        acc_s        = acc_r;
        idx_s        = idx_r;
        addr_pend_s  = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            ARM: begin
                if (en) begin
                    done_s       = 1'b0;
                    aggregated_s = 1'b0;
                    state_s      = IDLE;
                end else begin
                    state_s = ARM;
                end
            end
            IDLE: begin
                if (start) begin
                    address_s = FLAG_ADDR;
                    load_s    = 1'b1;
                    state_s   = RD_FLAG;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_FLAG: begin
                if (rd_valid_s) begin
                    if (bus.data_in != ZERO_W) begin
                        address_s = COUNT_ADDR;
                        load_s    = 1'b1;
                        state_s   = RD_CNT;
                    end else begin
                        aggregated_s = 1'b0;
                        state_s      = FINISH;
                    end
                end else begin
                    state_s = RD_FLAG;
                end
            end
            RD_CNT: begin
                if (rd_valid_s) begin
                    pkt_count_s = clamped_s;
                    acc_s       = {ACC_WIDTH{1'b0}};
                    idx_s       = ZERO_W;
                    if (clamped_s == ZERO_W) begin
                        state_s = WR_AGG;
                    end else begin
                        addr_pend_s = 1'b1;
                        state_s     = RD_PKT;
                    end
                end else begin
                    state_s = RD_CNT;
                end
            end
            RD_PKT: begin
                if (addr_pend_r) begin
                    address_s = PKT_BASE + idx_r;
                    load_s    = 1'b1;
                    state_s   = RD_PKT;
                end else if (rd_valid_s) begin
                    acc_s = acc_r + {{(ACC_WIDTH-WORD_WIDTH){1'b0}}, bus.data_in};
                    if ((idx_r + ONE_W) == pkt_count_r) begin
                        state_s = WR_AGG;
                    end else begin
                        idx_s       = idx_r + ONE_W;
                        addr_pend_s = 1'b1;
                        state_s     = RD_PKT;
                    end
                end else begin
                    state_s = RD_PKT;
                end
            end
            WR_AGG: begin
                address_s   = AGG_ADDR;
                data_out_s  = sat_word(acc_r);
                wr_en_s     = 1'b1;
                agg_value_s = sat_word(acc_r);
                state_s     = CLR_FLAG;
            end
            CLR_FLAG: begin
                address_s    = FLAG_ADDR;
                data_out_s   = ZERO_W;
                wr_en_s      = 1'b1;
                aggregated_s = 1'b1;
                state_s      = FINISH;
            end
            FINISH: begin
                wr_en_s = 1'b0;
                done_s  = 1'b1;
                state_s = ARM;
            end
            default: begin
                state_s = ARM;
            end
        endcase
    end

    // State and output registers; reset abandons any run in progress.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state_r      <= ARM;
            address_r    <= ZERO_W;
            data_out_r   <= ZERO_W;
            wr_en_r      <= 1'b0;
            aggregated_r <= 1'b0;
            agg_value_r  <= ZERO_W;
            pkt_count_r  <= ZERO_W;
            done_r       <= 1'b0;
            acc_r        <= {ACC_WIDTH{1'b0}};
            idx_r        <= ZERO_W;
            addr_pend_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            address_r    <= address_s;
            data_out_r   <= data_out_s;
            wr_en_r      <= wr_en_s;
            aggregated_r <= aggregated_s;
            agg_value_r  <= agg_value_s;
            pkt_count_r  <= pkt_count_s;
            done_r       <= done_s;
            acc_r        <= acc_s;
            idx_r        <= idx_s;
            addr_pend_r  <= addr_pend_s;
        end
    end

    assign bus.address  = address_r;
    assign bus.wr_en    = wr_en_r;
    assign bus.data_out = data_out_r;
    assign aggregated   = aggregated_r;
    assign agg_value    = agg_value_r;
    assign pkt_count    = pkt_count_r;
    assign done         = done_r;

endmodule

// File: tb/tb_aggregation_flag_reader.sv
// Drives three flag readers (READ_LAT 1, 2, 3) from one memory image and
// scoreboards their writes, read addresses, results and start-to-done latency.
module tb_aggregation_flag_reader;
    import aggregation_flag_reader_pkg::*;

    localparam int NL = 3;

    logic        clock = 1'b0;
    logic        nrst;
    logic        en;
    logic        start;
    logic [15:0] mem [0:255];

    logic [15:0] addr_a [NL];
    logic [15:0] dout_a [NL];
    logic [15:0] aggv_a [NL];
    logic [15:0] pcnt_a [NL];
    logic        wr_a   [NL];
    logic        done_a [NL];
    logic        aggd_a [NL];

    logic [31:0] exp_q [NL][$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < NL; g++) begin : lane
        aggregation_flag_reader_if bus ();
        logic [15:0] hist [0:1];

        // Read data reflects the address presented READ_LAT-1 cycles earlier.
        always @(posedge clock) begin
            hist[0] <= bus.address;
            hist[1] <= hist[0];
        end

        if (g == 0) begin : comb_rd
            assign bus.data_in = mem[bus.address[7:0]];
        end else begin : dly_rd
            assign bus.data_in = mem[hist[g-1][7:0]];
        end

        aggregation_flag_reader #(.MAX_PKTS(8), .READ_LAT(g + 1)) dut (
            .clock      (clock),
            .nrst       (nrst),
            .en         (en),
            .start      (start),
            .bus        (bus),
            .aggregated (aggd_a[g]),
            .agg_value  (aggv_a[g]),
            .pkt_count  (pcnt_a[g]),
            .done       (done_a[g])
        );

        assign addr_a[g] = bus.address;
        assign dout_a[g] = bus.data_out;
        assign wr_a[g]   = bus.wr_en;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < NL; k++) begin
            checks++;
            if ({addr_a[k], dout_a[k], aggv_a[k], pcnt_a[k], wr_a[k], done_a[k], aggd_a[k]} !== 67'd0) begin
                errors++;
                $display("FAIL %s lane%0d got addr=%h dout=%h agg=%h cnt=%h wr=%b done=%b aggd=%b required all zero",
                         name, k, addr_a[k], dout_a[k], aggv_a[k], pcnt_a[k], wr_a[k], done_a[k], aggd_a[k]);
            end
        end
    endtask

    // Runs one en/start pair and checks everything against a model of the memory image.
    task automatic run_case(input string name);
        bit            flag_set;
        int            n;
        int            sum;
        logic [15:0]   exp_sum;
        logic [255:0]  exp_map;
        logic [255:0]  map [NL];
        int            lat [NL];
        int            exp_lat [NL];
        logic [31:0]   e;
        bit            all_done;
        flag_set = (mem[2] != 16'h0000);
        n = 0;
        if (flag_set) n = (mem[3] > 16'd8) ? 8 : int'(mem[3]);
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(mem[16 + i]);
        exp_sum = (sum > 65535) ? 16'hFFFF : 16'(sum);
        exp_map = 256'd0;
        exp_map[2] = 1'b1;
        if (flag_set) begin
            exp_map[3] = 1'b1;
            exp_map[4] = 1'b1;
            for (int i = 0; i < n; i++) exp_map[16 + i] = 1'b1;
        end
        for (int k = 0; k < NL; k++) begin
            map[k] = 256'd0;
            lat[k] = 0;
            exp_lat[k] = flag_set ? (n + 2) * (k + 1) + n + 4 : (k + 1) + 2;
            if (flag_set) begin
                exp_q[k].push_back({16'h0004, exp_sum});
                exp_q[k].push_back({16'h0002, 16'h0000});
            end
        end
        arm();
        for (int k = 0; k < NL; k++) begin
            checks++;
            if (done_a[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s done_after_en lane%0d got %b required 0", name, k, done_a[k]);
            end
        end
        start = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            start = 1'b0;
            all_done = 1'b1;
            for (int k = 0; k < NL; k++) begin
                if (lat[k] == 0) begin
                    map[k][addr_a[k][7:0]] = 1'b1;
                    if (wr_a[k]) begin
                        checks++;
                        if (exp_q[k].size() == 0) begin
                            errors++;
                            $display("FAIL %s write lane%0d got %h/%h required no write", name, k, addr_a[k], dout_a[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            if ({addr_a[k], dout_a[k]} !== e) begin
                                errors++;
                                $display("FAIL %s write lane%0d got %h/%h required %h/%h",
                                         name, k, addr_a[k], dout_a[k], e[31:16], e[15:0]);
                            end
                        end
                    end
                    if (done_a[k] === 1'b1) lat[k] = c;
                    else all_done = 1'b0;
                end
            end
            if (all_done) break;
        end
        for (int k = 0; k < NL; k++) begin
            checks++;
            if (lat[k] != exp_lat[k]) begin
                errors++;
                $display("FAIL %s latency lane%0d got %0d required %0d (0 = timeout)", name, k, lat[k], exp_lat[k]);
            end
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL %s missing_writes lane%0d got %0d pending required 0", name, k, exp_q[k].size());
            end
            exp_q[k].delete();
            checks++;
            if (map[k] !== exp_map) begin
                errors++;
                $display("FAIL %s read_addrs lane%0d got %h required %h", name, k, map[k][63:0], exp_map[63:0]);
            end
            checks++;
            if (aggd_a[k] !== flag_set) begin
                errors++;
                $display("FAIL %s aggregated lane%0d got %b required %b", name, k, aggd_a[k], flag_set);
            end
            if (flag_set) begin
                checks++;
                if (aggv_a[k] !== exp_sum || pcnt_a[k] !== 16'(n)) begin
                    errors++;
                    $display("FAIL %s result lane%0d got agg=%h cnt=%0d required agg=%h cnt=%0d",
                             name, k, aggv_a[k], pcnt_a[k], exp_sum, n);
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b0; start = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        nrst = 1'b1;
        tick();
        check_all_zero("reset_release");
    endtask

    task automatic test_no_en(input string name);
        bit active [NL];
        for (int k = 0; k < NL; k++) active[k] = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) begin
            for (int k = 0; k < NL; k++)
                if (wr_a[k] || addr_a[k] != 16'h0000 || done_a[k]) active[k] = 1'b1;
            tick();
        end
        for (int k = 0; k < NL; k++) begin
            checks++;
            if (active[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s lane%0d got memory activity required none", name, k);
            end
        end
    endtask

    task automatic load_basic();
        mem[2] = 16'h0001; mem[3] = 16'h0003;
        mem[16] = 16'd5; mem[17] = 16'd7; mem[18] = 16'd9;
    endtask

    task automatic test_flag_clear();
        mem[2] = 16'h0000; mem[3] = 16'h0003;
        run_case("flag_clear");
    endtask

    task automatic test_basic();
        load_basic();
        run_case("basic");
    endtask

    task automatic test_back_to_back();
        repeat (3) tick();
        for (int k = 0; k < NL; k++) begin
            checks++;
            if (done_a[k] !== 1'b1) begin
                errors++;
                $display("FAIL done_hold lane%0d got %b required 1", k, done_a[k]);
            end
        end
        load_basic();
        mem[17] = 16'd100;
        run_case("back_to_back");
    endtask

    task automatic test_clamp_sat();
        mem[2] = 16'h0001; mem[3] = 16'd12;
        for (int i = 0; i < 16; i++) mem[16 + i] = 16'h4000;
        run_case("clamp_sat");
    endtask

    task automatic test_zero_count();
        mem[2] = 16'h0001; mem[3] = 16'h0000;
        run_case("zero_count");
    endtask

    task automatic test_nonzero_flag();
        mem[2] = 16'h8000; mem[3] = 16'h0002;
        mem[16] = 16'h1234; mem[17] = 16'h0FF0;
        run_case("nonzero_flag");
    endtask

    task automatic test_reset_mid();
        bit seen;
        load_basic();
        arm();
        start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            start = 1'b0;
            if (addr_a[2] == 16'h0010) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid wait got no payload read required lane2 at addr 0010");
        end
        nrst = 1'b0;
        tick();
        check_all_zero("reset_mid");
        nrst = 1'b1;
        tick();
        test_no_en("no_en_after_reset");
        test_basic();
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
        test_reset();
        test_no_en("no_en");
        test_flag_clear();
        test_basic();
        test_back_to_back();
        test_clamp_sat();
        test_zero_count();
        test_nonzero_flag();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
